// File: rtl/tlb_assoc_asid.sv
// N-way set-associative, thread-tagged TLB with true-LRU ages and a sequential flush walker.
// Optional hit/miss counters are enabled by defining TLB_PERF_CNT_EN.
module tlb_assoc_asid #(
  parameter int NUM_SETS    = 4,
  parameter int WAYS        = 4,
  parameter int VA_WIDTH    = 32,
  parameter int PA_WIDTH    = 20,
  parameter int PAGE_OFF    = 12,
  parameter int NUM_THREADS = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] req_thread_id,
  input  logic [VA_WIDTH-1:0]            req_virt_addr,
  input  logic                           req_supervisor,
  output logic                           rsp_valid,
  output logic                           rsp_miss,
  output logic [PA_WIDTH-1:0]            rsp_phy_addr,
  output logic                           rsp_write_priv,
  input  logic                           fill_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] fill_thread_id,
  input  logic [VA_WIDTH-1:0]            fill_virt_addr,
  input  logic [PA_WIDTH-1:0]            fill_phy_addr,
  input  logic                           fill_write_priv,
  input  logic                           flush_req,
  input  logic                           flush_all,
  input  logic [$clog2(NUM_THREADS)-1:0] flush_thread_id,
  output logic                           flush_busy,
  output logic                           flush_done
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
`endif
);
  localparam int SW    = $clog2(NUM_SETS);
  localparam int WW    = $clog2(WAYS);
  localparam int TW    = $clog2(NUM_THREADS);
  localparam int TAG_W = VA_WIDTH - PAGE_OFF - SW;
  localparam int PT_W  = PA_WIDTH - PAGE_OFF;

  typedef logic [WAYS-1:0][WW-1:0] ages_t;
  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SW-1:0]           r_fcnt;
  logic                    r_fall;
  logic [TW-1:0]           r_fthr;

  logic [NUM_SETS-1:0][WAYS-1:0] r_valid;
  ages_t [NUM_SETS-1:0]          r_age, w_age_nxt;
  logic [TAG_W-1:0]              r_tag [NUM_SETS][WAYS];
  logic [TW-1:0]                 r_thr [NUM_SETS][WAYS];
  logic [PT_W-1:0]               r_pa  [NUM_SETS][WAYS];
  logic                          r_wp  [NUM_SETS][WAYS];

  logic                    r_rsp_valid, r_rsp_miss, r_rsp_wp;
  logic [PA_WIDTH-1:0]     r_rsp_pa;

  logic [SW-1:0]           w_lk_set, w_fl_set;
  logic [TAG_W-1:0]        w_lk_tag, w_fl_tag;
  logic [WAYS-1:0]         w_hit_vec, w_fm_vec;
  logic [WW-1:0]           w_hit_way, w_fm_way, w_vict, w_fill_way;
  logic                    w_inv_found, w_walk, w_lk_hit, w_fill_en;
  ages_t                   w_fill_base;
  logic                    w_unused;

  assign w_lk_set = req_virt_addr[PAGE_OFF +: SW];
  assign w_lk_tag = req_virt_addr[VA_WIDTH-1 -: TAG_W];
  assign w_fl_set = fill_virt_addr[PAGE_OFF +: SW];
  assign w_fl_tag = fill_virt_addr[VA_WIDTH-1 -: TAG_W];
  assign w_walk   = (r_state == S_WALK);
  assign w_unused = ^{fill_phy_addr[PAGE_OFF-1:0], fill_virt_addr[PAGE_OFF-1:0]};

  // A flush request accepted in the same IDLE cycle as a fill takes priority.
  assign w_lk_hit  = req_valid && !req_supervisor && !w_walk && (|w_hit_vec);
  assign w_fill_en = fill_valid && !w_walk && !((r_state == S_IDLE) && flush_req);

  function automatic ages_t f_touch(input ages_t a, input logic [WW-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++)
      if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  always_comb begin
    w_hit_vec = '0;
    w_fm_vec  = '0;
    w_hit_way = '0;
    w_fm_way  = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_hit_vec[i] = r_valid[w_lk_set][i] && (r_tag[w_lk_set][i] == w_lk_tag) &&
                     (r_thr[w_lk_set][i] == req_thread_id);
      w_fm_vec[i]  = r_valid[w_fl_set][i] && (r_tag[w_fl_set][i] == w_fl_tag) &&
                     (r_thr[w_fl_set][i] == fill_thread_id);
    end
    for (int i = WAYS-1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WW'(i);
      if (w_fm_vec[i])  w_fm_way  = WW'(i);
    end
  end

  // Hit ageing lands first; the fill then ages on top of it when the sets coincide.
  always_comb begin
    w_age_nxt   = r_age;
    w_vict      = '0;
    w_inv_found = 1'b0;
    if (w_lk_hit) w_age_nxt[w_lk_set] = f_touch(r_age[w_lk_set], w_hit_way);
    w_fill_base = w_age_nxt[w_fl_set];
    for (int i = WAYS-1; i >= 0; i--)
      if (!r_valid[w_fl_set][i]) begin
        w_vict      = WW'(i);
        w_inv_found = 1'b1;
      end
    if (!w_inv_found)
      for (int i = 0; i < WAYS; i++)
        if (w_fill_base[i] == WW'(WAYS-1)) w_vict = WW'(i);
    w_fill_way = (|w_fm_vec) ? w_fm_way : w_vict;
    if (w_fill_en) w_age_nxt[w_fl_set] = f_touch(w_fill_base, w_fill_way);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (flush_req) w_state_nxt = S_WALK;
      S_WALK:  if (r_fcnt == SW'(NUM_SETS-1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_fall  <= 1'b0;
      r_fthr  <= '0;
      r_valid <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= WW'(w);
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
      if ((r_state == S_IDLE) && flush_req) begin
        r_fcnt <= '0;
        r_fall <= flush_all;
        r_fthr <= flush_thread_id;
      end else if (w_walk) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
      if (w_walk)
        for (int i = 0; i < WAYS; i++)
          if (r_fall || (r_thr[r_fcnt][i] == r_fthr)) r_valid[r_fcnt][i] <= 1'b0;
      if (w_fill_en) r_valid[w_fl_set][w_fill_way] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill_en) begin
      r_tag[w_fl_set][w_fill_way] <= w_fl_tag;
      r_thr[w_fl_set][w_fill_way] <= fill_thread_id;
      r_pa[w_fl_set][w_fill_way]  <= fill_phy_addr[PA_WIDTH-1:PAGE_OFF];
      r_wp[w_fl_set][w_fill_way]  <= fill_write_priv;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_miss  <= 1'b0;
      r_rsp_pa    <= '0;
      r_rsp_wp    <= 1'b0;
    end else begin
      r_rsp_valid <= req_valid;
      if (req_valid) begin
        if (req_supervisor) begin
          r_rsp_miss <= 1'b0;
          r_rsp_pa   <= req_virt_addr[PA_WIDTH-1:0];
          r_rsp_wp   <= 1'b1;
        end else if (w_lk_hit) begin
          r_rsp_miss <= 1'b0;
          r_rsp_pa   <= {r_pa[w_lk_set][w_hit_way], req_virt_addr[PAGE_OFF-1:0]};
          r_rsp_wp   <= r_wp[w_lk_set][w_hit_way];
        end else begin
          r_rsp_miss <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_miss       = r_rsp_miss;
  assign rsp_phy_addr   = r_rsp_pa;
  assign rsp_write_priv = r_rsp_wp;
  assign flush_busy     = w_walk;
  assign flush_done     = (r_state == S_DONE);

`ifdef TLB_PERF_CNT_EN
  logic r_rsp_user;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_user <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      r_rsp_user <= req_valid && !req_supervisor;
      if (r_rsp_valid && r_rsp_user) begin
        if (r_rsp_miss) begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
        end else begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlb_assoc_asid.sv
// Scoreboard bench for tlb_assoc_asid: stimulus queues expected responses, a monitor checks them.
module tb_tlb_assoc_asid;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_thread_id = '0;
  logic [31:0] req_virt_addr = '0;
  logic        req_supervisor = 1'b0;
  logic        rsp_valid, rsp_miss, rsp_write_priv;
  logic [19:0] rsp_phy_addr;
  logic        fill_valid = 1'b0;
  logic [1:0]  fill_thread_id = '0;
  logic [31:0] fill_virt_addr = '0;
  logic [19:0] fill_phy_addr = '0;
  logic        fill_write_priv = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_all = 1'b0;
  logic [1:0]  flush_thread_id = '0;
  logic        flush_busy, flush_done;
`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  tlb_assoc_asid dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_thread_id(req_thread_id),
    .req_virt_addr(req_virt_addr), .req_supervisor(req_supervisor),
    .rsp_valid(rsp_valid), .rsp_miss(rsp_miss),
    .rsp_phy_addr(rsp_phy_addr), .rsp_write_priv(rsp_write_priv),
    .fill_valid(fill_valid), .fill_thread_id(fill_thread_id),
    .fill_virt_addr(fill_virt_addr), .fill_phy_addr(fill_phy_addr),
    .fill_write_priv(fill_write_priv),
    .flush_req(flush_req), .flush_all(flush_all), .flush_thread_id(flush_thread_id),
    .flush_busy(flush_busy), .flush_done(flush_done)
`ifdef TLB_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        miss;
    logic [19:0] pa;
    logic        wp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_miss", 32'(rsp_miss), 32'(e.miss));
        if (!e.miss) begin
          chk("rsp_phy_addr", 32'(rsp_phy_addr), 32'(e.pa));
          chk("rsp_write_priv", 32'(rsp_write_priv), 32'(e.wp));
        end
      end
    end
  end

  task automatic lk(input logic [1:0] tid, input logic [31:0] va, input logic sup,
                    input logic em, input logic [19:0] ep, input logic ew);
    exp_t e;
    e.miss = em; e.pa = ep; e.wp = ew;
    q.push_back(e);
    req_valid = 1'b1; req_thread_id = tid; req_virt_addr = va; req_supervisor = sup;
    @(posedge clock); #1;
    req_valid = 1'b0; req_supervisor = 1'b0;
  endtask

  task automatic fill(input logic [1:0] tid, input logic [31:0] va, input logic [19:0] pa,
                      input logic wp);
    fill_valid = 1'b1; fill_thread_id = tid; fill_virt_addr = va;
    fill_phy_addr = pa; fill_write_priv = wp;
    @(posedge clock); #1;
    fill_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    #1;
    if (q.size() != 0) chk("rsp_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_miss", 32'(rsp_miss), 32'd0);
    chk("rst_rsp_phy_addr", 32'(rsp_phy_addr), 32'd0);
    chk("rst_rsp_write_priv", 32'(rsp_write_priv), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);

    // Cold miss, then fill and thread isolation
    lk(2'd0, 32'h0000_5123, 1'b0, 1'b1, 20'h0, 1'b0);
    fill(2'd0, 32'h0000_5000, 20'h0A000, 1'b0);
    lk(2'd0, 32'h0000_5123, 1'b0, 1'b0, 20'h0A123, 1'b0);
    @(posedge clock); #1;
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_rsp_phy_addr", 32'(rsp_phy_addr), 32'h0A123);
    lk(2'd1, 32'h0000_5123, 1'b0, 1'b1, 20'h0, 1'b0);
    lk(2'd0, 32'h0000_6123, 1'b0, 1'b1, 20'h0, 1'b0);
    drain();

    // LRU replacement in set 1
    do_reset();
    fill(2'd0, 32'h0000_1000, 20'hA1000, 1'b1);
    fill(2'd0, 32'h0000_5000, 20'hA5000, 1'b1);
    fill(2'd0, 32'h0000_9000, 20'hA9000, 1'b0);
    fill(2'd0, 32'h0000_D000, 20'hAD000, 1'b1);
    lk(2'd0, 32'h0000_1004, 1'b0, 1'b0, 20'hA1004, 1'b1);
    fill(2'd0, 32'h0001_1000, 20'hB1000, 1'b1);
    lk(2'd0, 32'h0000_5000, 1'b0, 1'b1, 20'h0, 1'b0);
    lk(2'd0, 32'h0000_1ABC, 1'b0, 1'b0, 20'hA1ABC, 1'b1);
    lk(2'd0, 32'h0000_9010, 1'b0, 1'b0, 20'hA9010, 1'b0);
    lk(2'd0, 32'h0000_D020, 1'b0, 1'b0, 20'hAD020, 1'b1);
    lk(2'd0, 32'h0001_1FFF, 1'b0, 1'b0, 20'hB1FFF, 1'b1);
    // refill of an existing (thread, tag) overwrites in place
    fill(2'd0, 32'h0000_9000, 20'hC9000, 1'b1);
    lk(2'd0, 32'h0000_9010, 1'b0, 1'b0, 20'hC9010, 1'b1);
    lk(2'd0, 32'h0001_1000, 1'b0, 1'b0, 20'hB1000, 1'b1);
    drain();

    // Thread-selective flush
    do_reset();
    fill(2'd0, 32'h0000_2000, 20'h11000, 1'b1);
    fill(2'd1, 32'h0000_2000, 20'h22000, 1'b0);
    flush_req = 1'b1; flush_all = 1'b0; flush_thread_id = 2'd0;
    @(posedge clock); #1;
    flush_req = 1'b0;
    chk("busy_c1", 32'(flush_busy), 32'd1);
    chk("done_c1", 32'(flush_done), 32'd0);
    lk(2'd1, 32'h0000_2123, 1'b0, 1'b1, 20'h0, 1'b0);
    chk("busy_c2", 32'(flush_busy), 32'd1);
    fill(2'd2, 32'h0000_6000, 20'h66000, 1'b1);
    chk("busy_c3", 32'(flush_busy), 32'd1);
    @(posedge clock); #1;
    chk("busy_c4", 32'(flush_busy), 32'd1);
    chk("done_c4", 32'(flush_done), 32'd0);
    @(posedge clock); #1;
    chk("done_pulse", 32'(flush_done), 32'd1);
    chk("busy_at_done", 32'(flush_busy), 32'd0);
    lk(2'd0, 32'h0000_2123, 1'b0, 1'b1, 20'h0, 1'b0);
    chk("done_cleared", 32'(flush_done), 32'd0);
    chk("busy_after", 32'(flush_busy), 32'd0);
    lk(2'd1, 32'h0000_2123, 1'b0, 1'b0, 20'h22123, 1'b0);
    lk(2'd2, 32'h0000_6000, 1'b0, 1'b1, 20'h0, 1'b0);
    drain();

    // Supervisor bypass leaves LRU alone: way 0 of set 3 stays the victim
    do_reset();
    fill(2'd0, 32'hFFFF_F000, 20'h5F000, 1'b0);
    fill(2'd0, 32'h0000_3000, 20'h53000, 1'b0);
    fill(2'd0, 32'h0000_7000, 20'h57000, 1'b0);
    fill(2'd0, 32'h0000_B000, 20'h5B000, 1'b0);
    lk(2'd0, 32'hFFFF_F123, 1'b1, 1'b0, 20'hFF123, 1'b1);
    fill(2'd0, 32'h0000_F000, 20'h5F000, 1'b1);
    lk(2'd0, 32'hFFFF_F123, 1'b0, 1'b1, 20'h0, 1'b0);
    lk(2'd0, 32'h0000_3123, 1'b0, 1'b0, 20'h53123, 1'b0);
    lk(2'd0, 32'h0000_F123, 1'b0, 1'b0, 20'h5F123, 1'b1);
    drain();

    // Reset during the second walk cycle
    do_reset();
    fill(2'd0, 32'h0000_4000, 20'h44000, 1'b1);
    fill(2'd1, 32'h0000_8000, 20'h48000, 1'b1);
    lk(2'd0, 32'h0000_4010, 1'b0, 1'b0, 20'h44010, 1'b1);
    flush_req = 1'b1; flush_all = 1'b0; flush_thread_id = 2'd3;
    @(posedge clock); #1;
    flush_req = 1'b0;
    chk("mid_busy_c1", 32'(flush_busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(flush_busy), 32'd0);
    chk("mid_rst_done", 32'(flush_done), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_busy", 32'(flush_busy), 32'd0);
    lk(2'd0, 32'h0000_4010, 1'b0, 1'b1, 20'h0, 1'b0);
    lk(2'd1, 32'h0000_8010, 1'b0, 1'b1, 20'h0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
